// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable strobe counter: end-of-count
// mode encoding and default parameter values.
package prog_counter_pkg;

    // End-of-count behaviour; the reserved code behaves as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : prog_counter_pkg

// File: rtl/strobe_sync_edge.sv
// Resynchronises an asynchronous strobe into the clk domain and produces a
// one-cycle pulse for each rising edge. Every flop resets to 1 so that a
// strobe held high through reset does not look like an edge after release.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one flop holding the previous synchronised level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : strobe_sync_edge

// File: rtl/prog_counter_gen.sv
// Programmable up/down counter of external strobe edges with parallel load,
// programmable limit and wrap / saturate / one-shot end-of-count modes.
// Optional snapshot register enabled by the macro PROG_COUNTER_CAPTURE_EN;
// without it, capture is ignored and cap_val reads 0.
module prog_counter_gen
    import prog_counter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cnt_strobe,
    input  logic             load,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    input  logic             capture,
    output logic [WIDTH-1:0] cap_val
);

    logic             edge_w;
    logic             event_w;
    mode_e            mode_w;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    strobe_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cnt_strobe),
        .edge_out (edge_w)
    );

    assign mode_w  = mode_e'(mode);
    // Events while disabled or after one-shot completion are simply lost.
    assign event_w = edge_w & enable & ~done_q;

    // Next-state: load has priority over a count event; tc defaults low.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
            done_d  = 1'b0;
        end else if (event_w) begin
            if (up_down) begin
                // ">=" so a limit lowered below the count ends the run at once.
                if (count_q >= limit) begin
                    tc_d = 1'b1;
                    case (mode_w)
                        MODE_SAT:     count_d = limit;
                        MODE_ONESHOT: begin
                            count_d = limit;
                            done_d  = 1'b1;
                        end
                        default:      count_d = '0;
                    endcase
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    case (mode_w)
                        MODE_SAT:     count_d = '0;
                        MODE_ONESHOT: begin
                            count_d = '0;
                            done_d  = 1'b1;
                        end
                        default:      count_d = limit;
                    endcase
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Counter, terminal-count pulse and sticky done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

`ifdef PROG_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q;

    // Snapshot takes the pre-update count, so it sees the old value even
    // when a load or event lands in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
        end else if (capture) begin
            cap_q <= count_q;
        end
    end

    assign cap_val = cap_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign cap_val        = '0;
`endif

endmodule : prog_counter_gen

// File: tb/tb_prog_counter_gen.sv
// Self-checking bench for prog_counter_gen with a behavioural model of the
// counter kept as plain integers.
module tb_prog_counter_gen;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             cnt_strobe;
    logic             load;
    logic             up_down;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             capture;
    logic [WIDTH-1:0] cap_val;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_count = 0;
    int m_done  = 0;
    int m_tc    = 0;
    int m_cap   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    prog_counter_gen #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cnt_strobe (cnt_strobe),
        .load       (load),
        .up_down    (up_down),
        .mode       (mode),
        .load_val   (load_val),
        .limit      (limit),
        .count      (count),
        .tc         (tc),
        .done       (done),
        .capture    (capture),
        .cap_val    (cap_val)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, int'(count), m_count);
        check_eq({tag, ".tc"},    int'(tc),    m_tc);
        check_eq({tag, ".done"},  int'(done),  m_done);
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp_load(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_event();
        int lim;
        lim  = int'(limit);
        m_tc = 0;
        if (!enable || m_done != 0) return;
        if (up_down) begin
            if (m_count >= lim) begin
                m_tc = 1;
                if (mode == 2'b01)      m_count = lim;
                else if (mode == 2'b10) begin m_count = lim; m_done = 1; end
                else                    m_count = 0;
            end else begin
                m_count = m_count + 1;
            end
        end else begin
            if (m_count == 0) begin
                m_tc = 1;
                if (mode == 2'b01)      m_count = 0;
                else if (mode == 2'b10) begin m_count = 0; m_done = 1; end
                else                    m_count = lim;
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_load(input int v);
        @(negedge clk);
        load_val = WIDTH'(v);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        m_count  = clamp_load(v, int'(limit));
        m_done   = 0;
        m_tc     = 0;
        check_state("load");
    endtask

    // One strobe pulse: high 3 cycles, low at least 3 cycles. Optionally a
    // load and/or capture is presented in the cycle the synchronised edge
    // is seen by the counter core.
    task automatic pulse(input string tag, input bit with_load, input int lval,
                         input bit with_cap);
        @(negedge clk);
        cnt_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Two edges after the rise: the count must not have moved yet.
        check_eq({tag, ".latency"}, int'(count), m_count);
        if (with_load) begin
            load     = 1'b1;
            load_val = WIDTH'(lval);
        end
        capture = with_cap;
        if (with_cap) m_cap = m_count;
        @(negedge clk);
        load       = 1'b0;
        capture    = 1'b0;
        cnt_strobe = 1'b0;
        if (with_load) begin
            m_count = clamp_load(lval, int'(limit));
            m_done  = 0;
            m_tc    = 0;
        end else begin
            model_event();
        end
        check_state(tag);
        @(negedge clk);
        check_eq({tag, ".tc_off"}, int'(tc), 0);
        m_tc = 0;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic setup(input bit ud, input int md, input int lim, input bit en);
        @(negedge clk);
        up_down = ud;
        mode    = 2'(md);
        limit   = WIDTH'(lim);
        enable  = en;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        cnt_strobe = 1'b1;   // held high through reset
        load       = 1'b0;
        up_down    = 1'b1;
        mode       = 2'b00;
        load_val   = '0;
        limit      = 8'd5;
        capture    = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        check_eq("reset.cap_val", int'(cap_val), 0);
        rst = 1'b0;

        // Strobe high across reset release must not generate an event.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_reset_hold", int'(count), 0);
        end
        cnt_strobe = 1'b0;
        repeat (4) @(negedge clk);

        // Wrap, up, limit 5: 1,2,3,4,5,0,1 with tc on the 6th event.
        setup(1'b1, 0, 5, 1'b1);
        for (int i = 0; i < 7; i++) pulse("wrap_up", 1'b0, 0, 1'b0);
        check_eq("wrap_up.final", int'(count), 1);

        // Down, saturate, from 2: 1,0,0,0; tc on 3rd and 4th.
        setup(1'b0, 1, 5, 1'b1);
        do_load(2);
        for (int i = 0; i < 4; i++) pulse("sat_down", 1'b0, 0, 1'b0);
        check_eq("sat_down.done", int'(done), 0);

        // One-shot, up, limit 3 from 2: 3 then done; further edges ignored.
        setup(1'b1, 2, 3, 1'b1);
        do_load(2);
        for (int i = 0; i < 3; i++) pulse("oneshot", 1'b0, 0, 1'b0);
        check_eq("oneshot.done_set", int'(done), 1);
        do_load(0);
        check_eq("oneshot.done_clr", int'(done), 0);

        // Load colliding with an edge: clamped to limit, edge dropped.
        setup(1'b1, 0, 'h10, 1'b1);
        pulse("load_edge", 1'b1, 'hF0, 1'b0);
        check_eq("load_edge.clamp", int'(count), 'h10);

        // Disabled events are discarded.
        setup(1'b1, 0, 'h10, 1'b0);
        for (int i = 0; i < 3; i++) pulse("disabled", 1'b0, 0, 1'b0);
        check_eq("disabled.final", int'(count), 'h10);

        // Limit 0: every up event terminal, count stays 0.
        setup(1'b1, 0, 0, 1'b1);
        do_load(0);
        for (int i = 0; i < 2; i++) pulse("limit0", 1'b0, 0, 1'b0);

        // Capture with a coinciding event.
        setup(1'b1, 0, 'hFF, 1'b1);
        do_load(7);
        pulse("capture", 1'b0, 0, 1'b1);
`ifdef PROG_COUNTER_CAPTURE_EN
        check_eq("capture.cap_val", int'(cap_val), m_cap);
        check_eq("capture.cap_const", int'(cap_val), 7);
`else
        check_eq("capture.cap_val", int'(cap_val), 0);
`endif
        check_eq("capture.count", int'(count), 8);

        // Randomised mixture of modes, directions, limits and loads.
        for (int i = 0; i < 60; i++) begin
            setup(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) do_load(int'($urandom_range(0, 12)));
            pulse("random", 1'b0, 0, 1'b0);
        end

        // Asynchronous reset mid-count at 0x44.
        setup(1'b1, 0, 'hFF, 1'b1);
        do_load('h44);
        #2;
        rst = 1'b1;
        #1;
        m_count = 0; m_tc = 0; m_done = 0;
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_state("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog in case the stimulus ever stalls.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_counter_gen
